ascon_perm_engine: RTL and testbench
====================================

# ascon_perm_engine

Parametrised, self-sequencing ASCON permutation engine: generalises the single-round `permutation` datapath by adding an internal round counter, a start/done handshake, run-time selection of p^a (12 rounds) or p^b (`ROUNDS_B` rounds), and `UNROLL` rounds per clock. It sits under the ASCON mode FSM. The FSM presents a 320-bit state, pulses `start_i`, and collects the result on `done_o`; it no longer drives `round_i`, `data_sel_i` or `en_reg_state_i` itself. State typing uses `type_state` (5 × 64-bit words, x0..x4) from `ascon_pack`.

## Interface
- `UNROLL`, default 1: rounds computed per clock. Legal values are 1 and 2; any other value is an elaboration error.
- `ROUNDS_B`, default 6: round count of p^b. Legal values are 6 (Ascon-128) and 8 (Ascon-128a); any other value is an elaboration error.
- `clock_i`  in  1  single clock, rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request a permutation; accepted only when `ready_o`=1.
- `mode_i`  in  1  0 selects p^a (12 rounds); 1 selects p^b (`ROUNDS_B` rounds). Sampled with `start_i`.
- `state_i`  in  320 (`type_state`)  input state. Sampled with `start_i`.
- `ready_o`  out  1  engine idle; can accept `start_i`.
- `done_o`  out  1  one-cycle pulse; `state_o` holds the finished permutation result.
- `state_o`  out  320 (`type_state`)  state register, driven directly with no output logic.

## Operation
- Round i (i = 0..11) applies three steps in order: pC, pS, pL.
  - pC: x2 ^= {56'h0, c_i}, with c_i = ((4'hF − i) << 4) | i. The sequence is 8'hF0, 8'hE1, … 8'h4B.
  - pS: the ASCON 5-bit S-box, applied bitsliced across the 64 columns.
  - pL: xk ^= (xk ⋙ a) ^ (xk ⋙ b), with (a, b) = x0:(19,28), x1:(61,39), x2:(1,6), x3:(10,17), x4:(7,41).
- An n-round permutation runs rounds i = 12−n … 11. p^6 starts at constant 8'h96; p^8 starts at constant 8'hB4.
- FSM states:
  - IDLE: `ready_o`=1.
    - On `start_i`=1: load `state_i` into the state register, set the 4-bit round counter to 12−n, go to RUN.
  - RUN: `ready_o`=0.
    - Each clock, apply rounds ctr … ctr+UNROLL−1 as a combinational chain, then ctr += UNROLL.
    - When ctr+UNROLL = 12, write the final state, go to IDLE, and register `done_o`=1.
- `done_o` is high in exactly the first IDLE cycle after a RUN. It is never asserted otherwise.
- `start_i` in RUN is ignored; there is no queuing.
- `start_i` in the `done_o` cycle is accepted (back-to-back operation). The result is visible in that cycle only, because the new load overwrites it at the next edge.
- In IDLE without `start_i`, the state register holds its value.
- Reset values: FSM=IDLE, state register=0, counter=0, `done_o`=0, `ready_o`=1.
- `reset_i` mid-RUN: abort at the next edge. Return to IDLE with zero state and no `done_o` pulse.
- `reset_i` and `start_i` on the same edge: reset wins and the start is dropped.
- Counter arithmetic is unsigned 4-bit. It never exceeds 12 because all legal n values are divisible by `UNROLL`.

## Timing
- `start_i` sampled at edge E0; rounds are applied at edges E1..Ek, with k = n/UNROLL; `done_o` is high between Ek and Ek+1.
- Start-to-done latency in clocks:

  | Permutation | UNROLL=1 | UNROLL=2 |
  |---|---|---|
  | p^12 | 12 | 6 |
  | p^8 | 8 | 4 |
  | p^6 | 6 | 3 |

- Back-to-back throughput: one permutation per k+1 clocks.
- Critical path: `UNROLL` chained rounds. At UNROLL=1 it must match the old single-round path.

## Test plan
- Reset behaviour: hold `reset_i`=1 for 2 cycles, then release.
  - Required: `ready_o`=1, `done_o`=0, `state_o`=0.
  - Required: `start_i`=1 together with `reset_i`=1 is ignored.
- p^12, UNROLL=1: `state_i` = {80400c0600000000, 0001020304050607, 08090a0b0c0d0e0f, 0011223344556677, 8899aabbccddeeff}.
  - Required: `done_o` rises exactly 12 clocks after the start edge.
  - Required: `state_o` equals the bench's golden round model, run 12 times with constants F0..4B.
  - Required: `ready_o`=0 for exactly 12 cycles.
- p^b, UNROLL=1, both `ROUNDS_B` settings:
  - `ROUNDS_B`=6: `done_o` at 6 clocks; result matches golden rounds 6..11, first constant 8'h96.
  - `ROUNDS_B`=8: `done_o` at 8 clocks; result matches golden rounds 4..11, first constant 8'hB4.
- UNROLL=2 equivalence: same vector as the p^12 test.
  - Required: p^12 completes in 6 clocks with a `state_o` bit-identical to the UNROLL=1 result.
  - Required: p^6 completes in 3 clocks.
- Handshake edges:
  - `start_i` pulsed mid-RUN: ignored, and the result is unchanged.
  - `start_i` in the `done_o` cycle: a second permutation starts; its `done_o` arrives k+1 clocks after the first.
  - `start_i` held high continuously: a `done_o` pulse every k+1 clocks.
- Abort: assert `reset_i` for 1 cycle at round 5 of p^12.
  - Required: next cycle IDLE, `state_o`=0, no `done_o` pulse.
  - Required: a subsequent start runs normally and its result matches golden.

Source files
------------

// File: rtl/ascon_perm_engine.sv
// Self-sequencing ASCON permutation: runs p^12 or p^ROUNDS_B from a start pulse,
// computing UNROLL chained rounds per clock and pulsing done_o with the result.
module ascon_perm_engine #(
  parameter int UNROLL   = 1,
  parameter int ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [319:0] state_i,
  output logic         ready_o,
  output logic         done_o,
  output logic [319:0] state_o
);

  if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1 or 2");
  end
  if (!(ROUNDS_B == 6 || ROUNDS_B == 8)) begin : g_bad_rounds_b
    $error("ascon_perm_engine: ROUNDS_B must be 6 or 8");
  end

  localparam logic [3:0] CTR_START_B = 4'(12 - ROUNDS_B);
  localparam logic [3:0] CTR_STEP    = 4'(UNROLL);
  localparam logic [3:0] CTR_LAST    = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    logic [127:0] dbl;
    dbl = {x, x} >> n;
    return dbl[63:0];
  endfunction

  // One full round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] rc);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    // (0xF - i) equals ~i in four bits, so the constant is {~i, i}
    x2 = x2 ^ {56'h0, ~rc, rc};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  fsm_t         fsm_q;
  logic [319:0] state_q;
  logic [3:0]   ctr_q;
  logic         done_q;
  logic         ready_q;

  logic [319:0] state_d;
  logic [3:0]   ctr_d;

  always_comb begin
    state_d = state_q;
    for (int u = 0; u < UNROLL; u++) begin
      state_d = ascon_round(state_d, ctr_q + 4'(u));
    end
    ctr_d = ctr_q + CTR_STEP;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= ST_IDLE;
      state_q <= 320'h0;
      ctr_q   <= 4'd0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= state_i;
            ctr_q   <= mode_i ? CTR_START_B : 4'd0;
            fsm_q   <= ST_RUN;
            ready_q <= 1'b0;
          end else begin
            fsm_q   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= state_d;
          ctr_q   <= ctr_d;
          if (ctr_d == CTR_LAST) begin
            fsm_q   <= ST_IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            fsm_q   <= ST_RUN;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          fsm_q   <= ST_IDLE;
          state_q <= 320'h0;
          ctr_q   <= 4'd0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Self-checking bench for ascon_perm_engine: three instances (U1/RB6, U1/RB8, U2/RB6)
// compared against a table-driven column S-box reference model.
module tb_ascon_perm_engine;

  logic         clk;
  logic         reset_s;
  logic         mode_s;
  logic [319:0] state_in_s;
  logic         start_s [3];
  logic         ready_s [3];
  logic         done_s  [3];
  logic [319:0] state_out_s [3];

  int checks   = 0;
  int failures = 0;

  int unroll_c [3] = '{1, 1, 2};
  int rb_c     [3] = '{6, 8, 6};

  logic [4:0] sbox [32] = '{5'd4, 5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9, 5'd2,
                            5'd27, 5'd5, 5'd8, 5'd18, 5'd29, 5'd3, 5'd6, 5'd28,
                            5'd30, 5'd19, 5'd7, 5'd14, 5'd0, 5'd13, 5'd17, 5'd24,
                            5'd16, 5'd12, 5'd1, 5'd25, 5'd22, 5'd10, 5'd15, 5'd23};

  ascon_perm_engine #(.UNROLL(1), .ROUNDS_B(6)) u_e0 (
    .clock_i(clk), .reset_i(reset_s), .start_i(start_s[0]), .mode_i(mode_s),
    .state_i(state_in_s), .ready_o(ready_s[0]), .done_o(done_s[0]), .state_o(state_out_s[0]));
  ascon_perm_engine #(.UNROLL(1), .ROUNDS_B(8)) u_e1 (
    .clock_i(clk), .reset_i(reset_s), .start_i(start_s[1]), .mode_i(mode_s),
    .state_i(state_in_s), .ready_o(ready_s[1]), .done_o(done_s[1]), .state_o(state_out_s[1]));
  ascon_perm_engine #(.UNROLL(2), .ROUNDS_B(6)) u_e2 (
    .clock_i(clk), .reset_i(reset_s), .start_i(start_s[2]), .mode_i(mode_s),
    .state_i(state_in_s), .ready_o(ready_s[2]), .done_o(done_s[2]), .state_o(state_out_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rot(input logic [63:0] x, input int a);
    return (x >> a) | (x << (64 - a));
  endfunction

  // Reference: rounds 12-n..11, S-box applied column by column via lookup table
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
    logic [63:0] w [5];
    logic [63:0] o [5];
    logic [4:0]  col;
    logic [4:0]  sv;
    int          c;
    for (int k = 0; k < 5; k++) w[k] = s[319 - 64*k -: 64];
    for (int r = 12 - n; r < 12; r++) begin
      c = ((15 - r) << 4) | r;
      w[2] = w[2] ^ 64'(c);
      for (int j = 0; j < 64; j++) begin
        col = {w[0][j], w[1][j], w[2][j], w[3][j], w[4][j]};
        sv  = sbox[col];
        for (int k = 0; k < 5; k++) o[k][j] = sv[4 - k];
      end
      w[0] = o[0] ^ rot(o[0], 19) ^ rot(o[0], 28);
      w[1] = o[1] ^ rot(o[1], 61) ^ rot(o[1], 39);
      w[2] = o[2] ^ rot(o[2], 1)  ^ rot(o[2], 6);
      w[3] = o[3] ^ rot(o[3], 10) ^ rot(o[3], 17);
      w[4] = o[4] ^ rot(o[4], 7)  ^ rot(o[4], 41);
    end
    return {w[0], w[1], w[2], w[3], w[4]};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_v(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One start pulse; optionally pokes start (with different inputs) mid-run at cycle 'poke'
  task automatic run_perm(input int idx, input logic mode, input logic [319:0] st,
                          input int poke, input string tag, output logic [319:0] res);
    int n, k, cyc, busy;
    bit got;
    n = mode ? rb_c[idx] : 12;
    k = n / unroll_c[idx];
    @(negedge clk);
    chk_i({tag, " ready_before"}, int'(ready_s[idx]), 1);
    state_in_s = st;
    mode_s = mode;
    start_s[idx] = 1'b1;
    @(posedge clk); #1;
    start_s[idx] = 1'b0;
    busy = (ready_s[idx] == 1'b0) ? 1 : 0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (cyc == poke) begin
        start_s[idx] = 1'b1;
        state_in_s = rand320();
        mode_s = ~mode;
      end
      @(posedge clk); #1;
      start_s[idx] = 1'b0;
      cyc++;
      if (done_s[idx]) got = 1'b1;
      else if (!ready_s[idx]) busy++;
    end
    chk_i({tag, " latency"}, cyc, k);
    chk_i({tag, " busy_cycles"}, busy, k);
    chk_i({tag, " ready_at_done"}, int'(ready_s[idx]), 1);
    chk_v({tag, " result"}, state_out_s[idx], model_perm(st, n));
    res = state_out_s[idx];
    @(posedge clk); #1;
    chk_i({tag, " done_one_cycle"}, int'(done_s[idx]), 0);
  endtask

  // start_i held high: a new state is offered in every done cycle
  task automatic held_run(input int idx, input logic mode, input int count, input string tag);
    int n, k, cyc, last, ndone;
    logic [319:0] st, exp;
    n = mode ? rb_c[idx] : 12;
    k = n / unroll_c[idx];
    st = rand320();
    exp = model_perm(st, n);
    @(negedge clk);
    state_in_s = st;
    mode_s = mode;
    start_s[idx] = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    last = 0;
    ndone = 0;
    while (ndone < count && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done_s[idx]) begin
        ndone++;
        chk_i({tag, " interval"}, cyc - last, (ndone == 1) ? k : k + 1);
        chk_v({tag, " result"}, state_out_s[idx], exp);
        last = cyc;
        st = rand320();
        exp = model_perm(st, n);
        state_in_s = st;
        if (ndone == count) start_s[idx] = 1'b0;
      end
    end
    start_s[idx] = 1'b0;
    chk_i({tag, " done_count"}, ndone, count);
    @(posedge clk); #1;
    chk_i({tag, " idle_after"}, int'(ready_s[idx]), 1);
  endtask

  initial begin
    logic [319:0] vec, r12, r_tmp;
    int ndone;
    vec = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
           64'h0011223344556677, 64'h8899aabbccddeeff};
    reset_s = 1'b1;
    mode_s = 1'b0;
    state_in_s = vec;
    for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
    start_s[0] = 1'b1;

    // Reset with a simultaneous start on instance 0: start must be dropped
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_s = 1'b0;
    start_s[0] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk_i($sformatf("reset ready e%0d", i), int'(ready_s[i]), 1);
      chk_i($sformatf("reset done e%0d", i), int'(done_s[i]), 0);
      chk_v($sformatf("reset state e%0d", i), state_out_s[i], 320'h0);
    end

    // p^12 directed vector on UNROLL=1, then on UNROLL=2 for bit equivalence
    run_perm(0, 1'b0, vec, -1, "p12_u1", r12);
    run_perm(2, 1'b0, vec, -1, "p12_u2", r_tmp);
    chk_v("u2_equiv_u1", r_tmp, r12);

    // p^b: 6 rounds (U1), 8 rounds (U1), 6 rounds (U2), random states
    for (int t = 0; t < 2; t++) begin
      run_perm(0, 1'b1, rand320(), -1, "p6_u1", r_tmp);
      run_perm(1, 1'b1, rand320(), -1, "p8_u1", r_tmp);
      run_perm(2, 1'b1, rand320(), -1, "p6_u2", r_tmp);
      run_perm(1, 1'b0, rand320(), -1, "p12_rb8", r_tmp);
    end

    // Start pulse during RUN must be ignored
    run_perm(0, 1'b0, rand320(), 3, "midrun_start_p12", r_tmp);
    run_perm(1, 1'b1, rand320(), 2, "midrun_start_p8", r_tmp);

    // Back-to-back via continuously held start
    held_run(0, 1'b1, 3, "held_p6_u1");
    held_run(2, 1'b1, 3, "held_p6_u2");
    held_run(1, 1'b0, 2, "held_p12_u1");

    // Abort: reset sampled on the edge after round 5 of p^12
    @(negedge clk);
    state_in_s = rand320();
    mode_s = 1'b0;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_s = 1'b1;
    @(posedge clk); #1;
    reset_s = 1'b0;
    chk_i("abort ready", int'(ready_s[0]), 1);
    chk_i("abort done", int'(done_s[0]), 0);
    chk_v("abort state", state_out_s[0], 320'h0);
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done_s[0]) ndone++;
    end
    chk_i("abort no_done", ndone, 0);
    chk_v("abort state_held", state_out_s[0], 320'h0);
    run_perm(0, 1'b0, rand320(), -1, "after_abort_p12", r_tmp);
    run_perm(0, 1'b1, rand320(), -1, "after_abort_p6", r_tmp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
